multicycle_ctrl: RTL and testbench

//  Multi-cycle main control FSM for the Scpu datapath; the driving end of the alu interface.
//  - Issues alu op[2:0] and operand selects every cycle.
//  - Consumes alu zero for beq.
//  - Sequences fetch / decode / execute / memory / writeback for a MIPS-like subset.
//  - Stalls on memory with a ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl_alu_op_decode.sv | 28 ++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared Scpu control constants: widths, opcode/funct codes, ALU op encodings,
// datapath select codes, controller state encoding and the decode dispatch helper.
package multicycle_ctrl_pkg;

  localparam int OPW     = 6;
  localparam int ALU_OPW = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;

  // Encodings shared with the alu op port.
  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b010;
  localparam logic [ALU_OPW-1:0] ALU_CMP = 3'b011;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALUWB   = 4'd3,
    S_MEMADR  = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWR   = 4'd6,
    S_MEMWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  // Where DECODE dispatches each opcode; unknown opcodes trap.
  function automatic state_e decode_target(input logic [OPW-1:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI: nxt = S_EXEC;
      OP_LW, OP_SW:              nxt = S_MEMADR;
      OP_BEQ:                    nxt = S_BRANCH;
      OP_J:                      nxt = S_JUMP;
      default:                   nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the Scpu datapath/memory (slave).
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OPW-1:0]     opcode;
  logic [OPW-1:0]     funct;
  logic               alu_zero;
  logic               mem_ready;

  logic               ir_write;
  logic               pc_write;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALU_OPW-1:0] alu_op;
  logic [1:0]         pc_src;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               illegal;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output ir_write, pc_write, iord, mem_read, mem_write, alu_src_a, alu_src_b,
           alu_op, pc_src, reg_write, reg_dst, mem_to_reg, illegal
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  ir_write, pc_write, iord, mem_read, mem_write, alu_src_a, alu_src_b,
           alu_op, pc_src, reg_write, reg_dst, mem_to_reg, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational ALU op selection from funct / instruction class; flags unsupported R-type functs.
// Kept standalone so a single-cycle controller can reuse it unchanged.
module alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPW-1:0]     funct_i,
  input  logic               is_rtype_i,
  input  logic               is_ori_i,
  output logic [ALU_OPW-1:0] alu_op_o,
  output logic               funct_ok_o
);

  always_comb begin
    alu_op_o   = ALU_ADD;
    funct_ok_o = 1'b1;
    if (is_rtype_i) begin
      case (funct_i)
        FN_ADD:  alu_op_o = ALU_ADD;
        FN_SUB:  alu_op_o = ALU_SUB;
        FN_OR:   alu_op_o = ALU_OR;
        default: funct_ok_o = 1'b0;
      endcase
    end else if (is_ori_i) begin
      alu_op_o = ALU_OR;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the Scpu datapath: Moore decode of the state register,
// except pc_write in BRANCH (follows alu_zero) and FETCH completion (follows mem_ready).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic               is_rtype, is_ori, funct_ok;
  logic [ALU_OPW-1:0] exec_op;

  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign is_ori   = (bus.opcode == OP_ORI);

  alu_op_decode u_alu_op_decode (
    .funct_i    (bus.funct),
    .is_rtype_i (is_rtype),
    .is_ori_i   (is_ori),
    .alu_op_o   (exec_op),
    .funct_ok_o (funct_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:  state_d = decode_target(bus.opcode);
      S_EXEC:    state_d = funct_ok ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:   state_d = S_FETCH;
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_MEMWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PCSRC_ALU;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = is_rtype ? SRCB_REG : SRCB_IMM;
        bus.alu_op    = exec_op;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = is_rtype;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_CMP;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.pc_write  = bus.alu_zero;
      end
      S_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
    // Reset wins in the same cycle, abandoning any stalled memory access.
    if (rst) begin
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_REG;
      bus.alu_op     = ALU_ADD;
      bus.pc_src     = PCSRC_ALU;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
    end
    bus.illegal = illegal_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction cycle schedule built from the ISA rules.
module tb_multicycle_ctrl;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_FADD = 6'b100000;
  localparam logic [5:0] T_FSUB = 6'b100010;
  localparam logic [5:0] T_FOR  = 6'b100101;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] op;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [5:0]  opc;
    logic [5:0]  fn;
    ctl_t        exp;
    ctl_t        mask;
    logic [95:0] tag;
  } step_t;

  logic  clk = 1'b0;
  logic  rst;
  step_t q[$];
  step_t st;
  int    checks = 0;
  int    errors = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observe();
    ctl_t c;
    c.ir_write   = bus.ir_write;
    c.pc_write   = bus.pc_write;
    c.iord       = bus.iord;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.src_a      = bus.alu_src_a;
    c.src_b      = bus.alu_src_b;
    c.op         = bus.alu_op;
    c.pc_src     = bus.pc_src;
    c.reg_write  = bus.reg_write;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    c.illegal    = bus.illegal;
    return c;
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic ctl_t m_all();
    ctl_t m = '1;
    return m;
  endfunction

  function automatic ctl_t m_no_ill();
    ctl_t m = '1;
    m.illegal = 1'b0;
    return m;
  endfunction

  // Expected control word of each instruction phase, straight from the ISA control table.
  function automatic ctl_t c_fetch(logic done);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.src_b = 2'd1; c.ir_write = done; c.pc_write = done;
    return c;
  endfunction

  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.src_b = 2'd3;
    return c;
  endfunction

  function automatic ctl_t c_exec(logic [5:0] opc, logic [5:0] fn);
    ctl_t c = '0;
    c.src_a = 1'b1;
    if (opc == T_R) begin
      c.src_b = 2'd0;
      c.op = (fn == T_FSUB) ? 3'd1 : (fn == T_FOR) ? 3'd2 : 3'd0;
    end else begin
      c.src_b = 2'd2;
      c.op = (opc == T_ORI) ? 3'd2 : 3'd0;
    end
    return c;
  endfunction

  function automatic ctl_t c_aluwb(logic rtype);
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = rtype;
    return c;
  endfunction

  function automatic ctl_t c_memadr();
    ctl_t c = '0;
    c.src_a = 1'b1; c.src_b = 2'd2;
    return c;
  endfunction

  function automatic ctl_t c_mem(logic is_load);
    ctl_t c = '0;
    c.iord = 1'b1; c.mem_read = is_load; c.mem_write = !is_load;
    return c;
  endfunction

  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_branch(logic z);
    ctl_t c = '0;
    c.src_a = 1'b1; c.op = 3'd3; c.pc_src = 2'd1; c.pc_write = z;
    return c;
  endfunction

  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.pc_src = 2'd2; c.pc_write = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_illegal();
    ctl_t c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

  function automatic void push(logic r, logic rdy, logic z, logic [5:0] opc, logic [5:0] fn,
                               ctl_t e, ctl_t m, logic [95:0] tag);
    step_t s;
    s.rst = r; s.rdy = rdy; s.zero = z; s.opc = opc; s.fn = fn;
    s.exp = e; s.mask = m; s.tag = tag;
    q.push_back(s);
  endfunction

  // One legal instruction: mem_ready/alu_zero are randomised wherever they must be ignored.
  function automatic void model_instr(logic [5:0] opc, logic [5:0] fn, int fstall, int mstall,
                                      logic z);
    for (int i = 0; i < fstall; i++)
      push(1'b0, 1'b0, rb(), opc, fn, c_fetch(1'b0), m_all(), "fetch_stall");
    push(1'b0, 1'b1, rb(), opc, fn, c_fetch(1'b1), m_all(), "fetch");
    push(1'b0, rb(), rb(), opc, fn, c_decode(), m_all(), "decode");
    case (opc)
      T_R, T_ADDI, T_ORI: begin
        push(1'b0, rb(), rb(), opc, fn, c_exec(opc, fn), m_all(), "exec");
        push(1'b0, rb(), rb(), opc, fn, c_aluwb(opc == T_R), m_all(), "aluwb");
      end
      T_LW, T_SW: begin
        push(1'b0, rb(), rb(), opc, fn, c_memadr(), m_all(), "memadr");
        for (int i = 0; i < mstall; i++)
          push(1'b0, 1'b0, rb(), opc, fn, c_mem(opc == T_LW), m_all(), "mem_stall");
        push(1'b0, 1'b1, rb(), opc, fn, c_mem(opc == T_LW), m_all(), "mem_done");
        if (opc == T_LW)
          push(1'b0, rb(), rb(), opc, fn, c_memwb(), m_all(), "memwb");
      end
      T_BEQ: push(1'b0, rb(), z, opc, fn, c_branch(z), m_all(), "branch");
      T_J:   push(1'b0, rb(), rb(), opc, fn, c_jump(), m_all(), "jump");
      default: ;
    endcase
  endfunction

  function automatic void idle_fetch();
    push(1'b0, 1'b0, rb(), T_R, T_FADD, c_fetch(1'b0), m_all(), "back_in_fetch");
  endfunction

  task automatic test_reset();
    push(1'b1, 1'b0, 1'b0, T_R, T_FADD, '0, m_no_ill(), "reset_c0");
    push(1'b1, 1'b0, 1'b1, T_R, T_FADD, '0, m_all(), "reset_c1");
    push(1'b1, 1'b1, 1'b1, T_R, T_FADD, '0, m_all(), "reset_rdy");
    push(1'b0, 1'b0, 1'b0, T_R, T_FADD, c_fetch(1'b0), m_all(), "post_reset");
    push(1'b0, 1'b0, 1'b0, T_R, T_FADD, c_fetch(1'b0), m_all(), "post_reset_hold");
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL reset/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    model_instr(T_R, T_FADD, 0, 0, 1'b0);
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL add/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    model_instr(T_LW, 6'd0, 0, 3, 1'b0);
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL lw_stall/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    model_instr(T_BEQ, 6'd0, 1, 0, 1'b1);
    model_instr(T_BEQ, 6'd0, 0, 0, 1'b0);
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL beq/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    ctl_t m_exec;
    m_exec = '1;
    m_exec.op = 3'b000;
    push(1'b0, 1'b1, 1'b0, 6'b111111, 6'd0, c_fetch(1'b1), m_all(), "fetch");
    push(1'b0, 1'b1, 1'b0, 6'b111111, 6'd0, c_decode(), m_all(), "decode");
    for (int i = 0; i < 20; i++)
      push(1'b0, rb(), rb(), 6'b111111, 6'd0, c_illegal(), m_all(), "trap_opcode");
    push(1'b1, 1'b1, 1'b0, 6'b111111, 6'd0, '0, m_no_ill(), "trap_rst");
    push(1'b0, 1'b0, 1'b0, T_R, 6'b100100, c_fetch(1'b0), m_all(), "cleared");
    push(1'b0, 1'b1, 1'b0, T_R, 6'b100100, c_fetch(1'b1), m_all(), "fetch");
    push(1'b0, 1'b0, 1'b0, T_R, 6'b100100, c_decode(), m_all(), "decode");
    push(1'b0, 1'b1, 1'b0, T_R, 6'b100100, c_exec(T_R, 6'b100100), m_exec, "exec_badfn");
    for (int i = 0; i < 4; i++)
      push(1'b0, rb(), rb(), T_R, 6'b100100, c_illegal(), m_all(), "trap_funct");
    push(1'b1, 1'b0, 1'b0, T_R, 6'b100100, '0, m_no_ill(), "trap_rst");
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL illegal/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_in_memwr();
    push(1'b0, 1'b1, 1'b0, T_SW, 6'd0, c_fetch(1'b1), m_all(), "fetch");
    push(1'b0, 1'b1, 1'b0, T_SW, 6'd0, c_decode(), m_all(), "decode");
    push(1'b0, 1'b1, 1'b0, T_SW, 6'd0, c_memadr(), m_all(), "memadr");
    push(1'b0, 1'b0, 1'b0, T_SW, 6'd0, c_mem(1'b0), m_all(), "memwr_stall");
    push(1'b0, 1'b0, 1'b0, T_SW, 6'd0, c_mem(1'b0), m_all(), "memwr_stall");
    push(1'b1, 1'b0, 1'b0, T_SW, 6'd0, '0, m_all(), "memwr_rst");
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL rst_memwr/%0s: dut=%h expected=%h", st.tag, observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[9] = '{T_R, T_R, T_R, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ, T_J};
    logic [5:0] fns[9] = '{T_FADD, T_FSUB, T_FOR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 8);
      model_instr(ops[k], fns[k], $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    idle_fetch();
    while (q.size() > 0) begin
      st = q.pop_front();
      rst = st.rst; bus.mem_ready = st.rdy; bus.alu_zero = st.zero;
      bus.opcode = st.opc; bus.funct = st.fn;
      @(negedge clk);
      checks++;
      if ((observe() & st.mask) !== (st.exp & st.mask)) begin
        errors++;
        $display("FAIL b2b/%0s op=%b fn=%b: dut=%h expected=%h", st.tag, st.opc, st.fn,
                 observe() & st.mask, st.exp & st.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;
    test_reset();
    test_add();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_rst_in_memwr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
